// File: rtl/mem_access_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states, request record
// and the read-latency mapping of the attached RAM.
package mem_access_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic int unsigned read_latency(input string perf);
    return (perf == "HIGH_PERFORMANCE") ? 2 : 1;
  endfunction

endpackage

// File: rtl/mem_data_align.sv
// Byte-lane alignment for stores and lane selection plus sign/zero extension for loads.
// Purely combinational: zero latency, no flow control.
module mem_data_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word[{byte_off, 3'b000} +: 8];
  assign ld_half = ld_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    st_be    = 4'b0000;
    st_lanes = st_data;
    ld_data  = '0;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << byte_off;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{ld_byte[7]}}, ld_byte};
      end
      F3_H: begin
        st_be    = 4'b0011 << byte_off;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{ld_half[15]}}, ld_half};
      end
      F3_W: begin
        st_be   = 4'b1111;
        ld_data = ld_word;
      end
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// RV32 load/store front end for a single-port RAM; response 1 (error), 2 (store) or 2+L (load) cycles after acceptance.
// One request in flight; a response is held in RESP until rsp_ready_i, and no request is taken meanwhile.
module memory_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned RAM_DEPTH       = 512,
  parameter string       RAM_PERFORMANCE = "LOW_LATENCY",
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [2:0]                   req_funct3_i,
  input  logic [31:0]                  req_addr_i,
  input  logic [31:0]                  req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [31:0]                  rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         mem_en_o,
  output logic [3:0]                   mem_we_o,
  output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_o,
  output logic [31:0]                  mem_din_o,
  output logic                         mem_regce_o,
  input  logic [31:0]                  mem_dout_i
);

  localparam int unsigned AW  = $clog2(RAM_DEPTH);
  localparam int unsigned LAT = read_latency(RAM_PERFORMANCE);

  state_e state_q, state_d;
  req_t   req_q, req_d, cur_req;
  logic   cnt_q, cnt_d;

  logic          mem_en_d, mem_regce_d, rsp_valid_d, rsp_err_d;
  logic [3:0]    mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [31:0]   mem_din_d, rsp_rdata_d;

  logic [31:0] offset, word_idx;
  logic        f3_ok, misaligned, out_of_range, req_err, wait_last;
  logic [3:0]  st_be;
  logic [31:0] st_lanes, ld_data;

  // In IDLE the live inputs are decoded; afterwards only the captured request matters.
  assign cur_req = (state_q == IDLE) ? {req_we_i, req_funct3_i, req_addr_i, req_wdata_i} : req_q;

  assign offset       = cur_req.addr - BASE_ADDR;
  assign word_idx     = offset >> 2;
  assign out_of_range = (cur_req.addr < BASE_ADDR) || (word_idx >= 32'(RAM_DEPTH));

  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    case (cur_req.funct3)
      F3_B:  f3_ok = 1'b1;
      F3_H: begin
        f3_ok      = 1'b1;
        misaligned = cur_req.addr[0];
      end
      F3_W: begin
        f3_ok      = 1'b1;
        misaligned = |cur_req.addr[1:0];
      end
      F3_BU: f3_ok = !cur_req.we;
      F3_HU: begin
        f3_ok      = !cur_req.we;
        misaligned = cur_req.addr[0];
      end
      default: ;
    endcase
  end

  assign req_err     = !f3_ok || misaligned || out_of_range;
  assign wait_last   = (LAT == 1) || cnt_q;
  assign req_ready_o = (state_q == IDLE) && rst_ni;

  mem_data_align u_align (
    .funct3   (cur_req.funct3),
    .byte_off (cur_req.addr[1:0]),
    .st_data  (cur_req.wdata),
    .ld_word  (mem_dout_i),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_o;
    mem_din_d   = mem_din_o;
    mem_regce_d = 1'b0;
    rsp_valid_d = rsp_valid_o;
    rsp_err_d   = rsp_err_o;
    rsp_rdata_d = rsp_rdata_o;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d = cur_req;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = ACCESS;
            mem_en_d   = 1'b1;
            mem_addr_d = word_idx[AW-1:0];
            if (cur_req.we) begin
              mem_we_d  = st_be;
              mem_din_d = st_lanes;
            end
          end
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d     = WAIT;
          cnt_d       = 1'b0;
          mem_regce_d = 1'b1;
        end
      end
      WAIT: begin
        if (wait_last) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
        end else begin
          cnt_d       = 1'b1;
          mem_regce_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 4'b0000;
      mem_addr_o  <= '0;
      mem_din_o   <= '0;
      mem_regce_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mem_en_o    <= mem_en_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_din_o   <= mem_din_d;
      mem_regce_o <= mem_regce_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Drives a LOW_LATENCY and a HIGH_PERFORMANCE instance in lockstep, each with its own RAM model;
// expected responses are queued at acceptance and matched when each instance responds.
module tb_memory_access_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic        mem_en    [2];
  logic        mem_regce [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] mem_din   [2];
  logic [31:0] mem_dout  [2];
  logic [3:0]  mem_we    [2];
  logic [3:0]  mem_addr  [2];

  logic [31:0] ram0 [DEPTH];
  logic [31:0] ram1 [DEPTH];
  logic [31:0] stage1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   rd_idx [2] = '{0, 0};
  logic seen [2] = '{1'b0, 1'b0};
  int   memen_cnt [2] = '{0, 0};
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_access_unit #(.RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("LOW_LATENCY")) u_ll (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]),
    .mem_addr_o(mem_addr[0]), .mem_din_o(mem_din[0]), .mem_regce_o(mem_regce[0]),
    .mem_dout_i(mem_dout[0])
  );

  memory_access_unit #(.RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE")) u_hp (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]),
    .mem_addr_o(mem_addr[1]), .mem_din_o(mem_din[1]), .mem_regce_o(mem_regce[1]),
    .mem_dout_i(mem_dout[1])
  );

  // Read-first RAMs: one read stage for the low-latency part, plus a regce-gated output register for the other.
  always @(posedge clk) begin
    if (mem_en[0]) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[0][b]) ram0[mem_addr[0]][8*b +: 8] <= mem_din[0][8*b +: 8];
      mem_dout[0] <= ram0[mem_addr[0]];
    end
  end

  always @(posedge clk) begin
    if (mem_en[1]) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[1][b]) ram1[mem_addr[1]][8*b +: 8] <= mem_din[1][8*b +: 8];
      stage1 <= ram1[mem_addr[1]];
    end
    if (mem_regce[1]) mem_dout[1] <= stage1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        seen[k]      = 1'b0;
        memen_cnt[k] = 0;
      end else begin
        if (mem_en[k]) memen_cnt[k]++;
        if (rsp_valid[k] && !seen[k]) begin
          if (rd_idx[k] >= sb.size()) begin
            chk($sformatf("spurious_rsp%0d", k), 32'(rsp_valid[k]), 32'd0);
          end else begin
            exp_t e;
            int   lat;
            e   = sb[rd_idx[k]];
            lat = e.err ? 1 : (e.we ? 2 : 3 + k);
            chk($sformatf("rdata%0d_#%0d", k, rd_idx[k]), rsp_rdata[k], e.rdata);
            chk($sformatf("err%0d_#%0d", k, rd_idx[k]), 32'(rsp_err[k]), 32'(e.err));
            chk($sformatf("latency%0d_#%0d", k, rd_idx[k]), 32'(cyc - e.acc + 1), 32'(lat));
            chk($sformatf("mem_en_cycles%0d_#%0d", k, rd_idx[k]), 32'(memen_cnt[k]), e.err ? 32'd0 : 32'd1);
            rd_idx[k]++;
            memen_cnt[k] = 0;
          end
        end
        seen[k] = rsp_valid[k];
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_req_ready%0d", tag, k), 32'(req_ready[k]), 32'd0);
      chk($sformatf("%s_rsp_valid%0d", tag, k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("%s_rsp_err%0d", tag, k), 32'(rsp_err[k]), 32'd0);
      chk($sformatf("%s_rsp_rdata%0d", tag, k), rsp_rdata[k], 32'd0);
      chk($sformatf("%s_mem_en%0d", tag, k), 32'(mem_en[k]), 32'd0);
      chk($sformatf("%s_mem_we%0d", tag, k), 32'(mem_we[k]), 32'd0);
      chk($sformatf("%s_mem_addr%0d", tag, k), 32'(mem_addr[k]), 32'd0);
      chk($sformatf("%s_mem_din%0d", tag, k), mem_din[k], 32'd0);
      chk($sformatf("%s_mem_regce%0d", tag, k), 32'(mem_regce[k]), 32'd0);
    end
  endtask

  // Called on a falling edge; returns just after the accepting rising edge (cycle T+1).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input bit push);
    int n = 0;
    while (!(req_ready[0] && req_ready[1]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", {30'd0, req_ready[1], req_ready[0]}, 32'd3);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{exp_rd, exp_err, we, cyc});
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rd_idx[0] != sb.size() || rd_idx[1] != sb.size()) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen_ll", 32'(rd_idx[0]), 32'(sb.size()));
    chk("rsp_seen_hp", 32'(rd_idx[1]), 32'(sb.size()));
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_rd);
    issue(1'b0, f3, addr, $urandom, exp_rd, 1'b0, 1'b1);
    wait_done();
  endtask

  task automatic err_req(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    issue(we, f3, addr, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
    wait_done();
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] exp_be, input logic [31:0] exp_din, input logic [3:0] exp_idx);
    issue(1'b1, f3, addr, wd, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("access_en%0d", k), 32'(mem_en[k]), 32'd1);
      chk($sformatf("access_we%0d", k), 32'(mem_we[k]), 32'(exp_be));
      chk($sformatf("access_din%0d", k), mem_din[k], exp_din);
      chk($sformatf("access_addr%0d", k), 32'(mem_addr[k]), 32'(exp_idx));
    end
    wait_done();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {30'd0, req_ready[1], req_ready[0]}, 32'd3);

    st(3'b010, 32'h0, 32'h80FF_FF7F, 4'b1111, 32'h80FF_FF7F, 4'd0);
    ld(3'b000, 32'h3, 32'hFFFF_FF80);
    ld(3'b100, 32'h3, 32'h0000_0080);
    ld(3'b000, 32'h0, 32'h0000_007F);
    ld(3'b001, 32'h0, 32'hFFFF_FF7F);
    ld(3'b101, 32'h2, 32'h0000_80FF);
    ld(3'b010, 32'h0, 32'h80FF_FF7F);

    st(3'b010, 32'h4, 32'h0, 4'b1111, 32'h0, 4'd1);
    st(3'b000, 32'h6, 32'h1234_56AB, 4'b0100, 32'hABAB_ABAB, 4'd1);
    ld(3'b010, 32'h4, 32'h00AB_0000);
    st(3'b001, 32'h6, 32'h9999_BEEF, 4'b1100, 32'hBEEF_BEEF, 4'd1);
    ld(3'b010, 32'h4, 32'hBEEF_0000);
    ld(3'b001, 32'h6, 32'hFFFF_BEEF);

    st(3'b010, 32'h0, 32'h8001_1234, 4'b1111, 32'h8001_1234, 4'd0);
    ld(3'b001, 32'h2, 32'hFFFF_8001);
    st(3'b010, 32'h3C, 32'h5A5A_0001, 4'b1111, 32'h5A5A_0001, 4'd15);
    ld(3'b010, 32'h3C, 32'h5A5A_0001);

    err_req(1'b0, 3'b010, 32'h2);
    err_req(1'b1, 3'b010, 32'(4 * DEPTH));
    err_req(1'b0, 3'b001, 32'h1);
    err_req(1'b0, 3'b011, 32'h0);
    err_req(1'b1, 3'b100, 32'h0);
    err_req(1'b1, 3'b001, 32'h3);
    err_req(1'b0, 3'b010, 32'hFFFF_FFFC);

    // Consumer stalls the response for five cycles.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall_valid%0d", k), 32'(rsp_valid[k]), 32'd1);
        chk($sformatf("stall_rdata%0d", k), rsp_rdata[k], 32'hFFFF_8001);
        chk($sformatf("stall_err%0d", k), 32'(rsp_err[k]), 32'd0);
        chk($sformatf("stall_ready%0d", k), 32'(req_ready[k]), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_stall_ready", {30'd0, req_ready[1], req_ready[0]}, 32'd3);
    chk("idle_after_stall_valid", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);

    // Reset lands while both instances sit in WAIT; the load must vanish.
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_wait");
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {30'd0, req_ready[1], req_ready[0]}, 32'd3);
    chk("rst_release_valid", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);
    ld(3'b010, 32'h0, 32'h8001_1234);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
